// File: rtl/fp_min_reduce_ctrl.sv
// Streaming FP min-reduction sequencer: folds each packet of operands into a running
// minimum and presents one result per packet with beat count, NaN and zero flags.
module fp_min_reduce_ctrl #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_vld,
    output logic                              in_rdy,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0]   in_data,
    input  logic                              in_last,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0]   out_data,
    output logic [CNT_W-1:0]                  out_cnt,
    output logic                              out_nan,
    output logic                              out_zero
);

    localparam int FP_W  = SIGN_W + EXPO_W + MANT_W;
    localparam int MAG_W = EXPO_W + MANT_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [FP_W-1:0]  QNAN    = {{SIGN_W{1'b0}}, {EXPO_W{1'b1}}, 1'b1,
                                            {(MANT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]      state_q, state_d;
    logic [FP_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            accept;

    function automatic logic is_nan(input logic [FP_W-1:0] v);
        return (v[MANT_W +: EXPO_W] == {EXPO_W{1'b1}}) && (v[MANT_W-1:0] != '0);
    endfunction

    function automatic logic zero_chk(input logic [FP_W-1:0] v);
        return v[MAG_W-1:0] == '0;
    endfunction

    // a is the accumulator: ties keep a; a lone NaN yields the other operand.
    function automatic logic [FP_W-1:0] fp_min(input logic [FP_W-1:0] a,
                                               input logic [FP_W-1:0] b);
        logic             a_nan, b_nan, b_less;
        logic [MAG_W-1:0] a_mag, b_mag;
        a_nan = is_nan(a);
        b_nan = is_nan(b);
        a_mag = a[MAG_W-1:0];
        b_mag = b[MAG_W-1:0];
        if (a_nan && b_nan) return QNAN;
        if (a_nan) return b;
        if (b_nan) return a;
        if (a[FP_W-1] != b[FP_W-1]) b_less = b[FP_W-1];
        else if (a[FP_W-1])         b_less = b_mag > a_mag;
        else                        b_less = b_mag < a_mag;
        return b_less ? b : a;
    endfunction

    assign in_rdy = !rst && (state_q != ST_OUT);
    assign accept = in_vld && in_rdy;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    cnt_d   = CNT_ONE;
                    state_d = in_last ? ST_OUT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    acc_d = fp_min(acc_q, in_data);
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    if (in_last) state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_vld  = (state_q == ST_OUT);
    assign out_data = acc_q;
    assign out_cnt  = cnt_q;
    assign out_nan  = is_nan(acc_q);
    assign out_zero = zero_chk(acc_q);

endmodule

// File: tb/tb_fp_min_reduce_ctrl.sv
// Bench for fp_min_reduce_ctrl: packet table with a result scoreboard, plus backpressure,
// mid-packet reset and counter saturation sequences (second instance with CNT_W=2).
module tb_fp_min_reduce_ctrl;

    logic        clk, rst;
    logic        in_vld, in_rdy, in_last;
    logic [31:0] in_data;
    logic        out_vld, out_rdy, out_nan, out_zero;
    logic [31:0] out_data;
    logic [15:0] out_cnt;

    logic        d2_in_rdy, d2_out_vld, d2_out_nan, d2_out_zero;
    logic [31:0] d2_out_data;
    logic [1:0]  d2_out_cnt;

    fp_min_reduce_ctrl dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_last(in_last), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_cnt(out_cnt), .out_nan(out_nan), .out_zero(out_zero)
    );

    fp_min_reduce_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(d2_in_rdy), .in_data(in_data),
        .in_last(in_last), .out_vld(d2_out_vld), .out_rdy(out_rdy), .out_data(d2_out_data),
        .out_cnt(d2_out_cnt), .out_nan(d2_out_nan), .out_zero(d2_out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               n;
        logic [4:0][31:0] beats;
        logic [31:0]      data;
        logic [15:0]      cnt;
        logic             nan;
        logic             zero;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [15:0] cnt;
        logic        nan;
        logic        zero;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic add_vec(input int n, input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3,
                           input logic [31:0] b4, input logic [31:0] d,
                           input logic [15:0] c, input logic nan, input logic zero);
        vec_t v;
        v.n = n;
        v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3; v.beats[4] = b4;
        v.data = d; v.cnt = c; v.nan = nan; v.zero = zero;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [15:0] c, input logic nan,
                            input logic zero);
        exp_t e;
        e.data = d; e.cnt = c; e.nan = nan; e.zero = zero;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge after the beat was accepted.
    task automatic send_beat(input logic [31:0] d, input logic last, input int stall);
        int   waited = 0;
        logic took;
        in_vld  = 1'b1;
        in_data = d;
        in_last = last;
        forever begin
            took = in_rdy;
            @(posedge clk);
            if (took || waited >= 20) break;
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        chk("accept_wait", 32'(took), 32'd1);
        in_vld  = 1'b0;
        in_last = 1'b0;
        repeat (stall) @(negedge clk);
    endtask

    task automatic get_result(input bit bp);
        exp_t e;
        int   waited = 0;
        while (!out_vld && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("out_vld", 32'(out_vld), 32'd1);
        chk("latency", 32'(waited), 32'd0);
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        if (bp) begin
            repeat (5) begin
                chk("bp_in_rdy", 32'(in_rdy), 32'd0);
                chk("bp_out_vld", 32'(out_vld), 32'd1);
                chk("bp_data", out_data, e.data);
                @(negedge clk);
            end
        end
        chk("out_data", out_data, e.data);
        chk("out_cnt", 32'(out_cnt), 32'(e.cnt));
        chk("out_nan", 32'(out_nan), 32'(e.nan));
        chk("out_zero", 32'(out_zero), 32'(e.zero));
        out_rdy = 1'b1;
        @(posedge clk);
        #1 out_rdy = 1'b0;
        @(negedge clk);
        chk("idle_out_vld", 32'(out_vld), 32'd0);
        chk("idle_in_rdy", 32'(in_rdy), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_out_nan", 32'(out_nan), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_data = '0; in_last = 1'b0; out_rdy = 1'b0;

        add_vec(3, 32'h40400000, 32'hBF800000, 32'h40000000, 0, 0, 32'hBF800000, 3, 0, 0);
        add_vec(2, 32'h00000000, 32'h80000000, 0, 0, 0, 32'h80000000, 2, 0, 1);
        add_vec(2, 32'h80000000, 32'h00000000, 0, 0, 0, 32'h80000000, 2, 0, 1);
        add_vec(3, 32'h7F800001, 32'h7F800000, 32'h7FC00123, 0, 0, 32'h7F800000, 3, 0, 0);
        add_vec(2, 32'h7FA00000, 32'h7FC00001, 0, 0, 0, 32'h7FC00000, 2, 1, 0);
        add_vec(1, 32'h7FA00001, 0, 0, 0, 0, 32'h7FA00001, 1, 1, 0);
        add_vec(3, 32'hC0000000, 32'hC0400000, 32'hBF800000, 0, 0, 32'hC0400000, 3, 0, 0);
        add_vec(4, 32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h00800000, 0,
                32'hFF800000, 4, 0, 0);
        add_vec(3, 32'h40000000, 32'h3F000000, 32'h3F800000, 0, 0, 32'h3F000000, 3, 0, 0);
        add_vec(2, 32'h3F800000, 32'h7FC00000, 0, 0, 0, 32'h3F800000, 2, 0, 0);
        add_vec(2, 32'h00000000, 32'h80000001, 0, 0, 0, 32'h80000001, 2, 0, 0);
        add_vec(1, 32'h80000000, 0, 0, 0, 0, 32'h80000000, 1, 0, 1);

        #12 chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 32'(in_rdy), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            push_exp(vecs[i].data, vecs[i].cnt, vecs[i].nan, vecs[i].zero);
            for (int j = 0; j < vecs[i].n; j++)
                send_beat(vecs[i].beats[j], j == vecs[i].n - 1, (j == vecs[i].n - 1) ? 0 : i % 3);
            get_result(i == 0);
        end

        // Reset in the middle of a packet.
        send_beat(32'h40000000, 1'b0, 0);
        send_beat(32'hC0000000, 1'b0, 0);
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_exp(32'h3F800000, 16'd1, 1'b0, 1'b0);
        send_beat(32'h3F800000, 1'b1, 0);
        get_result(0);

        // Five-beat packet: 16-bit counter reads 5, 2-bit counter saturates at 3.
        push_exp(32'hC1A00000, 16'd5, 1'b0, 1'b0);
        send_beat(32'h40000000, 1'b0, 1);
        send_beat(32'hC1200000, 1'b0, 0);
        send_beat(32'h3F800000, 1'b0, 2);
        send_beat(32'hC1A00000, 1'b0, 0);
        send_beat(32'h00000000, 1'b1, 0);
        chk("d2_out_vld", 32'(d2_out_vld), 32'd1);
        chk("d2_out_cnt", 32'(d2_out_cnt), 32'd3);
        chk("d2_out_data", d2_out_data, 32'hC1A00000);
        get_result(0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
